reg_universal_ce: RTL
=====================

Name: reg_universal_ce

Overview:
- Parametrised successor to the single-mode enabled D register.
- SIZE-bit register with a synchronous, clock-enabled mode select: hold, parallel load, shift, rotate, increment and decrement.
- Registered carry-out and zero flags.
- Used as accumulator, shift register, program counter or loop counter in the uProcessor datapath, so one block serves every register role.

Parameters:
- SIZE, 8: register width in bits; legal range 2 to 32.
- SET, 0: reset value of Q, SIZE bits wide.

Ports:
- clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset; sampled only on the rising edge of clk.
- CE  input  1  clock enable. When 0, all state holds regardless of Mode.
- Mode  input  3  operation select; encoding is under Behaviour.
- D  input  SIZE  parallel load data.
- SIn  input  1  serial input for SHL/SHR.
- Q  output  SIZE  register contents.
- Cout  output  1  registered carry/borrow/shifted-out bit.
- Zero  output  1  registered flag, high when Q == 0.

Behaviour:
- One clock; synchronous, active-high reset. All state updates on the rising edge of clk only; no combinational path from inputs to outputs.
- Priority at each edge: Reset, then CE=0 (hold), then Mode.
- Reset=1: Q <= SET; Cout <= 0; Zero <= (SET == 0). Reset overrides CE and Mode.
- Reset asserted mid-sequence (e.g. during a counting run) takes effect on that edge; the next operation starts from SET.
- CE=0: Q, Cout and Zero all hold.
- Mode encoding, applied when CE=1. Qn is the next value of Q.
  - 000 HOLD: Qn = Q; Cout holds.
  - 001 LOAD: Qn = D; Cout <= 0.
  - 010 SHL: Qn = {Q[SIZE-2:0], SIn}; Cout <= Q[SIZE-1].
  - 011 SHR: Qn = {SIn, Q[SIZE-1:1]}; Cout <= Q[0].
  - 100 ROL: Qn = {Q[SIZE-2:0], Q[SIZE-1]}; Cout <= Q[SIZE-1].
  - 101 ROR: Qn = {Q[0], Q[SIZE-1:1]}; Cout <= Q[0].
  - 110 INC: Qn = Q + 1, modulo 2^SIZE. Cout <= 1 only when Q was all ones (wrap to 0).
  - 111 DEC: Qn = Q - 1, modulo 2^SIZE. Cout <= 1 only when Q was 0 (borrow, wrap to all ones).
- Arithmetic is unsigned, SIZE bits. The carry is taken from a SIZE+1-bit intermediate; no saturation.
- Zero <= (Qn == 0), registered on the same edge as Q, so Zero is always consistent with Q. In HOLD, Zero is unchanged.
- Latency: one cycle from the sampled inputs to Q, Cout and Zero.
- SIn is ignored except in SHL and SHR. D is ignored except in LOAD.
- Back-to-back operations on consecutive cycles are legal; each operation uses the Q produced by the previous edge.
- X or Z on Mode while CE=1 is illegal. The bench asserts against it; the RTL behaviour in that case is unspecified.

Decomposition:
- Shared package uproc_pkg holds:
  - typedef reg_mode_t, a 3-bit enum: MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_INC, MODE_DEC.
  - localparam REG_MODE_W = 3.
- One combinational sub-module, reg_universal_next, computes {Cout_n, Qn} from Q, D, SIn and Mode.
- The top level holds only the priority logic and the flops, so the next-state logic can be unit-tested on its own.

Test Plan:
All scenarios use SIZE=8 and SET=8'hA5.
1. Reset=1 for one edge -> Q=A5, Cout=0, Zero=0. Then CE=0 with Mode=LOAD, D=00 for 3 cycles -> Q stays A5.
2. LOAD D=FF, then INC -> Q=00, Cout=1, Zero=1. A second INC -> Q=01, Cout=0, Zero=0.
3. LOAD 00, then DEC -> Q=FF, Cout=1, Zero=0. DEC again -> Q=FE, Cout=0.
4. LOAD 81, then SHL with SIn=0 -> Q=02, Cout=1. Then SHR with SIn=1 -> Q=81, Cout=0. Then ROR -> Q=C0, Cout=1. Then ROL -> Q=81, Cout=1.
5. Reset asserted together with CE=1, Mode=INC and Q=10 -> Q=A5 (reset wins). Repeat with SET=0 -> Zero=1 after reset.
6. Random regression, 10k cycles: random Mode, CE, D and SIn with occasional Reset -> every cycle Q, Cout and Zero match a reference model. Coverage required: every mode hit with CE=1 and with CE=0, and every Cout=1 case.

Source files
------------

// File: rtl/uproc_pkg.sv
// Shared definitions for the uProcessor datapath registers.
package uproc_pkg;

    localparam int REG_MODE_W = 3;

    // Operation select for the universal register.
    typedef enum logic [REG_MODE_W-1:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_INC  = 3'b110,
        MODE_DEC  = 3'b111
    } reg_mode_t;

endpackage

// File: rtl/reg_universal_next.sv
// Combinational next-state logic of the universal register: given the
// current contents and the operation, produce the next contents and carry.
module reg_universal_next
    import uproc_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0]       q,
    input  logic                  cout,
    input  logic [SIZE-1:0]       d,
    input  logic                  sin,
    input  logic [REG_MODE_W-1:0] mode,
    output logic [SIZE-1:0]       q_n,
    output logic                  cout_n
);

    reg_mode_t mode_e;
    assign mode_e = reg_mode_t'(mode);

    // Select the operation; carry for INC/DEC comes from a SIZE+1-bit result.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        q_n    = q;
        cout_n = cout;
        case (mode_e)
            MODE_HOLD: begin
                q_n    = q;
                cout_n = cout;
            end
            MODE_LOAD: begin
                q_n    = d;
                cout_n = 1'b0;
            end
            MODE_SHL: begin
                q_n    = {q[SIZE-2:0], sin};
                cout_n = q[SIZE-1];
            end
            MODE_SHR: begin
                q_n    = {sin, q[SIZE-1:1]};
                cout_n = q[0];
            end
            MODE_ROL: begin
                q_n    = {q[SIZE-2:0], q[SIZE-1]};
                cout_n = q[SIZE-1];
            end
            MODE_ROR: begin
                q_n    = {q[0], q[SIZE-1:1]};
                cout_n = q[0];
            end
            MODE_INC: {cout_n, q_n} = {1'b0, q} + (SIZE+1)'(1);
            MODE_DEC: {cout_n, q_n} = {1'b0, q} - (SIZE+1)'(1);
            default: begin
                q_n    = q;
                cout_n = cout;
            end
        endcase
    end

endmodule

// File: rtl/reg_universal_ce.sv
// Universal SIZE-bit datapath register: hold, load, shift, rotate,
// increment and decrement under a clock enable, with registered carry
// and zero flags. Serves as accumulator, shifter, PC or loop counter.
module reg_universal_ce
    import uproc_pkg::*;
#(
    parameter int              SIZE = 8,
    parameter logic [SIZE-1:0] SET  = '0
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  CE,
    input  logic [REG_MODE_W-1:0] Mode,
    input  logic [SIZE-1:0]       D,
    input  logic                  SIn,
    output logic [SIZE-1:0]       Q,
    output logic                  Cout,
    output logic                  Zero
);

    logic [SIZE-1:0] q_q, q_d, q_n;
    logic            cout_q, cout_d, cout_n;
    logic            zero_q, zero_d;

    reg_universal_next #(.SIZE(SIZE)) u_next (
        .q      (q_q),
        .cout   (cout_q),
        .d      (D),
        .sin    (SIn),
        .mode   (Mode),
        .q_n    (q_n),
        .cout_n (cout_n)
    );

    // Clock enable gates the operation; Zero tracks the value being written.
    always_comb begin
        q_d    = q_q;
        cout_d = cout_q;
        zero_d = zero_q;
        if (CE) begin
            q_d    = q_n;
            cout_d = cout_n;
            zero_d = (q_n == '0);
        end
    end

    // State flops; synchronous reset takes priority over everything else.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all flops update from pre-edge values.
        if (Reset) begin
            q_q    <= SET;
            cout_q <= 1'b0;
            zero_q <= (SET == '0);
        end else begin
            q_q    <= q_d;
            cout_q <= cout_d;
            zero_q <= zero_d;
        end
    end

    assign Q    = q_q;
    assign Cout = cout_q;
    assign Zero = zero_q;

endmodule
